// File: rtl/frame_classifier_if.sv
// Pixel-stream and classification-result bundle between the camera path and the classifier.
// PIXEL_VALID qualifies PIXEL_IN and both coordinates in the same cycle; there is no backpressure.
interface frame_classifier_if;
    logic [7:0] PIXEL_IN;
    logic       PIXEL_VALID;
    logic [9:0] VGA_PIXEL_X;
    logic [9:0] VGA_PIXEL_Y;
    logic       VGA_VSYNC_NEG;
    logic [3:0] RESULT;
    logic       RESULT_VALID;
    logic [3:0] FRAME_CLASS;

    modport master (
        output PIXEL_IN, PIXEL_VALID, VGA_PIXEL_X, VGA_PIXEL_Y, VGA_VSYNC_NEG,
        input  RESULT, RESULT_VALID, FRAME_CLASS
    );

    modport slave (
        input  PIXEL_IN, PIXEL_VALID, VGA_PIXEL_X, VGA_PIXEL_Y, VGA_VSYNC_NEG,
        output RESULT, RESULT_VALID, FRAME_CLASS
    );
endinterface

// File: rtl/frame_classifier.sv
// Per-frame RGB332 colour/shape classifier with row-run shape measurement and N-frame debounce.
// dbg_state encoding: 0 ACCUM, 1 CLOSE, 2 CLASSIFY, 3 VOTE.
module frame_classifier #(
    parameter int WIDTH        = 176,
    parameter int HEIGHT       = 144,
    parameter int CNT_W        = 15,
    parameter int COLOR_THRESH = 300,
    parameter int TOL          = 6,
    parameter int DEBOUNCE     = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    frame_classifier_if.slave bus,
    output logic [1:0]        dbg_state
);
    localparam int SW = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(COLOR_THRESH);
    localparam logic [9:0]       X_LAST  = 10'(WIDTH - 1);
    localparam logic [3:0]       DEB     = 4'(DEBOUNCE);

    typedef enum logic [1:0] {ACCUM = 2'd0, CLOSE = 2'd1, CLASSIFY = 2'd2, VOTE = 2'd3} state_t;
    state_t state, state_nxt;

    logic             vsync_q, fall_q;
    logic [CNT_W-1:0] red_cnt, blue_cnt, row_cnt, top_w, bottom_w;
    logic [9:0]       min_x, max_x, last_y;
    logic             got_top;
    logic [3:0]       frame_class, prev_class, result, streak, streak_nxt;
    logic             result_valid;
    logic             clear_acc, do_classify, do_vote;

    logic accept, pix_red, pix_blue, pix_col, row_close;
    logic [1:0] colour_c, shape_c;
    logic [SW-1:0] box_w, top_tol, bot_tol;

    assign accept = bus.PIXEL_VALID && (bus.VGA_PIXEL_X < 10'(WIDTH)) &&
                    (bus.VGA_PIXEL_Y < 10'(HEIGHT)) && (state == ACCUM);
    assign pix_red   = (bus.PIXEL_IN[7:5] >= 3'd6) && (bus.PIXEL_IN[1:0] <= 2'd1);
    assign pix_blue  = (bus.PIXEL_IN[1:0] == 2'd3) && (bus.PIXEL_IN[7:5] <= 3'd2);
    assign pix_col   = accept && (pix_red || pix_blue);
    assign row_close = (accept && (bus.VGA_PIXEL_Y != last_y)) || (state == CLOSE);

    // Only an edge seen while accumulating may start a frame close.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vsync_q <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            vsync_q <= bus.VGA_VSYNC_NEG;
            fall_q  <= vsync_q && !bus.VGA_VSYNC_NEG && (state == ACCUM);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ACCUM;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:    if (fall_q) state_nxt = CLOSE;
            CLOSE:    state_nxt = CLASSIFY;
            CLASSIFY: state_nxt = VOTE;
            VOTE:     state_nxt = ACCUM;
            default:  state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        clear_acc   = 1'b0;
        do_classify = 1'b0;
        do_vote     = 1'b0;
        case (state)
            CLASSIFY: do_classify = 1'b1;
            VOTE: begin
                do_vote   = 1'b1;
                clear_acc = 1'b1;
            end
            default: ;
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            red_cnt  <= '0;
            blue_cnt <= '0;
            row_cnt  <= '0;
            top_w    <= '0;
            bottom_w <= '0;
            got_top  <= 1'b0;
            min_x    <= X_LAST;
            max_x    <= '0;
            last_y   <= '0;
        end else if (clear_acc) begin
            red_cnt  <= '0;
            blue_cnt <= '0;
            row_cnt  <= '0;
            top_w    <= '0;
            bottom_w <= '0;
            got_top  <= 1'b0;
            min_x    <= X_LAST;
            max_x    <= '0;
            last_y   <= '0;
        end else begin
            if (pix_col && pix_red && red_cnt != CNT_MAX)   red_cnt  <= red_cnt + CNT_W'(1);
            if (pix_col && pix_blue && blue_cnt != CNT_MAX) blue_cnt <= blue_cnt + CNT_W'(1);
            if (pix_col && bus.VGA_PIXEL_X < min_x) min_x <= bus.VGA_PIXEL_X;
            if (pix_col && bus.VGA_PIXEL_X > max_x) max_x <= bus.VGA_PIXEL_X;
            if (accept) last_y <= bus.VGA_PIXEL_Y;
            // A row boundary banks the finished run; the incoming pixel seeds the next one.
            if (row_close) begin
                if (row_cnt != '0) begin
                    bottom_w <= row_cnt;
                    if (!got_top) begin
                        top_w   <= row_cnt;
                        got_top <= 1'b1;
                    end
                end
                row_cnt <= pix_col ? CNT_W'(1) : '0;
            end else if (pix_col && row_cnt < ROW_MAX) begin
                row_cnt <= row_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        box_w   = SW'(max_x) - SW'(min_x) + SW'(1);
        top_tol = {1'b0, top_w} + SW'(TOL);
        bot_tol = {1'b0, bottom_w} + SW'(TOL);
        colour_c = 2'd0;
        if (red_cnt > blue_cnt && red_cnt >= THRESH)       colour_c = 2'd1;
        else if (blue_cnt > red_cnt && blue_cnt >= THRESH) colour_c = 2'd2;
        shape_c = 2'd0;
        if (colour_c != 2'd0) begin
            if (top_tol >= box_w && bot_tol >= box_w) shape_c = 2'd1;
            else if (bot_tol >= box_w)                shape_c = 2'd2;
            else                                      shape_c = 2'd3;
        end
    end

    assign streak_nxt = (frame_class != prev_class) ? 4'd1 :
                        (streak >= DEB) ? DEB : streak + 4'd1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            frame_class  <= '0;
            prev_class   <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            streak       <= '0;
        end else begin
            result_valid <= 1'b0;
            if (do_classify) frame_class <= {shape_c, colour_c};
            if (do_vote) begin
                prev_class <= frame_class;
                streak     <= streak_nxt;
                if (streak_nxt == DEB && frame_class != result) begin
                    result       <= frame_class;
                    result_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.RESULT       = result;
    assign bus.RESULT_VALID = result_valid;
    assign bus.FRAME_CLASS  = frame_class;
endmodule

// File: tb/tb_frame_classifier.sv
// Bench for frame_classifier: fixed frame table, reset/vsync corner sequences, then random
// frames scored against a pixel-list reference model and a sliding-window debounce model.
module tb_frame_classifier;
    localparam int WIDTH  = 176;
    localparam int HEIGHT = 144;
    localparam int DEB    = 4;
    localparam logic [7:0] RED  = 8'hC0;
    localparam logic [7:0] BLUE = 8'h23;

    typedef enum int {K_SPARSE, K_TIE, K_OOR, K_RSQ, K_RTRI, K_BTRI, K_BDIA} kind_t;
    typedef struct {
        kind_t      kind;
        logic [3:0] cls;
        logic [3:0] res;
        bit         pulse;
    } vec_t;
    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] d;
        logic       v;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] dbg_state;
    frame_classifier_if bus ();

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] hist[$];
    logic [3:0] model_result = 4'd0;
    pix_t frame_q[$];
    vec_t tbl[19];

    frame_classifier #(.DEBOUNCE(DEB)) dut (
        .CLK(clk), .RESET(rst), .bus(bus), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_pix(input int x, input int y, input logic [7:0] d, input logic v);
        pix_t p;
        p.x = 10'(x); p.y = 10'(y); p.d = d; p.v = v;
        frame_q.push_back(p);
    endtask

    task automatic add_run(input int y, input int x0, input int len, input logic [7:0] d);
        for (int i = 0; i < len; i++) add_pix(x0 + i, y, d, 1'b1);
    endtask

    task automatic build(input kind_t k);
        frame_q.delete();
        case (k)
            K_SPARSE: for (int r = 0; r < 10; r++) add_run(30 + r, 40, 20, RED);
            K_TIE: begin
                for (int r = 0; r < 10; r++) add_run(10 + r, 30, 50, RED);
                for (int r = 0; r < 10; r++) add_run(20 + r, 30, 50, BLUE);
            end
            K_OOR: begin
                for (int r = 0; r < 16; r++) add_run(20 + r, 20, 16, RED);
                for (int i = 0; i < 60; i++) add_pix(WIDTH, 36, RED, 1'b1);
                for (int i = 0; i < 60; i++) add_pix(20 + i, 37, RED, 1'b0);
                for (int i = 0; i < 60; i++) add_pix(20 + i, HEIGHT, RED, 1'b1);
            end
            K_RSQ:  for (int r = 0; r < 40; r++) add_run(50 + r, 60, 40, RED);
            K_RTRI: for (int r = 0; r <= 40; r++) add_run(20 + r, 60, r + 1, RED);
            K_BTRI: for (int r = 0; r <= 40; r++) add_run(20 + r, 60, r + 1, BLUE);
            K_BDIA: for (int r = 0; r <= 80; r++) begin
                int w;
                w = 41 - ((r > 40) ? r - 40 : 40 - r);
                add_run(20 + r, 60 + (41 - w) / 2, w, BLUE);
            end
            default: ;
        endcase
    endtask

    // Reference classification straight from the colour/shape rules over the pixel list.
    function automatic logic [3:0] model_class();
        int red = 0, blue = 0, minx = 1 << 20, maxx = -1, top = 0, bot = 0, w;
        int rowc[HEIGHT];
        bit seen = 0;
        logic [1:0] col = 2'd0, shp = 2'd0;
        foreach (rowc[i]) rowc[i] = 0;
        foreach (frame_q[i]) begin
            pix_t p;
            bit is_r, is_b;
            p = frame_q[i];
            if (p.v && p.x < WIDTH && p.y < HEIGHT) begin
                is_r = (p.d[7:5] >= 6) && (p.d[1:0] <= 1);
                is_b = (p.d[1:0] == 3) && (p.d[7:5] <= 2);
                if (is_r) red++;
                if (is_b) blue++;
                if (is_r || is_b) begin
                    rowc[p.y]++;
                    if (int'(p.x) < minx) minx = int'(p.x);
                    if (int'(p.x) > maxx) maxx = int'(p.x);
                end
            end
        end
        for (int y = 0; y < HEIGHT; y++) begin
            if (rowc[y] > 0) begin
                if (!seen) top = (rowc[y] > WIDTH) ? WIDTH : rowc[y];
                seen = 1;
                bot = (rowc[y] > WIDTH) ? WIDTH : rowc[y];
            end
        end
        if (red > blue && red >= 300) col = 2'd1;
        else if (blue > red && blue >= 300) col = 2'd2;
        if (col != 2'd0) begin
            w = maxx - minx + 1;
            if (top + 6 >= w && bot + 6 >= w) shp = 2'd1;
            else if (bot + 6 >= w) shp = 2'd2;
            else shp = 2'd3;
        end
        return {shp, col};
    endfunction

    // Debounce reference: RESULT follows once the last DEB frame classes all agree.
    task automatic model_step(input logic [3:0] cls, output logic [3:0] res, output bit pulse);
        bit same = 1;
        hist.push_back(cls);
        if (hist.size() > DEB) void'(hist.pop_front());
        foreach (hist[i]) if (hist[i] != cls) same = 0;
        pulse = (hist.size() == DEB) && same && (cls != model_result);
        if (pulse) model_result = cls;
        res = model_result;
    endtask

    task automatic stream_frame();
        foreach (frame_q[i]) begin
            bus.PIXEL_IN    = frame_q[i].d;
            bus.VGA_PIXEL_X = frame_q[i].x;
            bus.VGA_PIXEL_Y = frame_q[i].y;
            bus.PIXEL_VALID = frame_q[i].v;
            @(posedge clk); #1;
        end
        bus.PIXEL_VALID = 1'b0;
    endtask

    // mode: 0 plain, 1 extra vsync edge in CLASSIFY, 2 extra edge in VOTE, 3 reset in VOTE.
    task automatic end_frame(input logic [3:0] exp_res, input bit exp_pulse, input int mode);
        logic [3:0] exp_cls;
        int pulses = 0;
        exp_cls = exp_q.pop_front();
        bus.VGA_VSYNC_NEG = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.RESULT_VALID) pulses++;
            case (c)
                1: bus.VGA_VSYNC_NEG = 1'b1;
                3: if (mode == 1) bus.VGA_VSYNC_NEG = 1'b0;
                4: begin
                    check("frame_class", bus.FRAME_CLASS, exp_cls);
                    if (mode == 2) bus.VGA_VSYNC_NEG = 1'b0;
                    if (mode == 3) rst = 1'b1;
                end
                5: begin
                    if (mode == 3) check("frame_class_after_reset", bus.FRAME_CLASS, 4'd0);
                    check("result", bus.RESULT, exp_res);
                    check("result_valid_at_5", bus.RESULT_VALID, exp_pulse);
                    if (mode == 3) rst = 1'b0;
                end
                6: if (mode == 1 || mode == 2) bus.VGA_VSYNC_NEG = 1'b1;
                default: ;
            endcase
            if ((mode == 1 || mode == 2) && c >= 6) check("state_accum_after_glitch", dbg_state, 2'd0);
        end
        check("pulse_count", pulses, exp_pulse);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0] r, cls;
        bit p;
        int reps;
        tbl[0]  = '{K_SPARSE, 4'b0000, 4'b0000, 0};
        tbl[1]  = '{K_TIE,    4'b0000, 4'b0000, 0};
        tbl[2]  = '{K_OOR,    4'b0000, 4'b0000, 0};
        tbl[3]  = '{K_RSQ,    4'b0101, 4'b0000, 0};
        tbl[4]  = '{K_RSQ,    4'b0101, 4'b0000, 0};
        tbl[5]  = '{K_RSQ,    4'b0101, 4'b0000, 0};
        tbl[6]  = '{K_RTRI,   4'b1001, 4'b0000, 0};
        tbl[7]  = '{K_RSQ,    4'b0101, 4'b0000, 0};
        tbl[8]  = '{K_RSQ,    4'b0101, 4'b0000, 0};
        tbl[9]  = '{K_RSQ,    4'b0101, 4'b0000, 0};
        tbl[10] = '{K_RSQ,    4'b0101, 4'b0101, 1};
        tbl[11] = '{K_BTRI,   4'b1010, 4'b0101, 0};
        tbl[12] = '{K_BTRI,   4'b1010, 4'b0101, 0};
        tbl[13] = '{K_BTRI,   4'b1010, 4'b0101, 0};
        tbl[14] = '{K_BTRI,   4'b1010, 4'b1010, 1};
        tbl[15] = '{K_BDIA,   4'b1110, 4'b1010, 0};
        tbl[16] = '{K_BDIA,   4'b1110, 4'b1010, 0};
        tbl[17] = '{K_BDIA,   4'b1110, 4'b1010, 0};
        tbl[18] = '{K_BDIA,   4'b1110, 4'b1110, 1};

        // clock/reset
        bus.PIXEL_IN = '0; bus.PIXEL_VALID = 1'b0;
        bus.VGA_PIXEL_X = '0; bus.VGA_PIXEL_Y = '0; bus.VGA_VSYNC_NEG = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_result", bus.RESULT, 4'd0);
        check("reset_result_valid", bus.RESULT_VALID, 1'b0);
        check("reset_frame_class", bus.FRAME_CLASS, 4'd0);
        check("reset_state", dbg_state, 2'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // fixed frame table
        for (int i = 0; i < 19; i++) begin
            build(tbl[i].kind);
            exp_q.push_back(tbl[i].cls);
            model_step(tbl[i].cls, r, p);
            stream_frame();
            end_frame(tbl[i].res, tbl[i].pulse, 0);
        end

        // reset during VOTE of the frame that would have changed RESULT
        frame_q.delete();
        for (int rr = 0; rr < 18; rr++) add_run(10 + rr, 10, 18, RED);
        for (int f = 0; f < 4; f++) begin
            exp_q.push_back(4'b0101);
            stream_frame();
            if (f < 3) begin
                model_step(4'b0101, r, p);
                end_frame(r, p, 0);
            end else begin
                end_frame(4'd0, 0, 3);
            end
        end
        hist.delete();
        model_result = 4'd0;

        // stray vsync edges outside ACCUM must not open extra frames
        for (int f = 0; f < 4; f++) begin
            exp_q.push_back(4'b0101);
            model_step(4'b0101, r, p);
            stream_frame();
            end_frame(r, p, (f == 0) ? 1 : (f == 1) ? 2 : 0);
        end

        // random frames, each repeated a few times so the debounce can settle
        for (int k = 0; k < 8; k++) begin
            int dom, ny, y0;
            frame_q.delete();
            dom = $urandom_range(0, 2);
            ny  = $urandom_range(12, 28);
            y0  = $urandom_range(0, HEIGHT - 12);
            for (int rr = 0; rr < ny; rr++) begin
                int xs, len;
                xs  = $urandom_range(0, 160);
                len = $urandom_range(10, 30);
                for (int i = 0; i < len; i++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    if (dom != 0 && $urandom_range(0, 3) != 0)
                        d = (dom == 1) ? {3'($urandom_range(6, 7)), 3'($urandom), 2'($urandom_range(0, 1))}
                                       : {3'($urandom_range(0, 2)), 3'($urandom), 2'd3};
                    add_pix(xs + i, y0 + rr, d, $urandom_range(0, 19) != 0);
                end
            end
            cls  = model_class();
            reps = $urandom_range(1, 4);
            for (int f = 0; f < reps; f++) begin
                exp_q.push_back(cls);
                model_step(cls, r, p);
                stream_frame();
                end_frame(r, p, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
